// File: rtl/keypad_pkg.sv
// keypad_pkg: state encoding, key codes and the row/column key map for keypad_scanner.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, PRESS_DB, HOLD, REL_DB} state_t;
  localparam logic [3:0] KEY_0 = 4'd0;
  localparam logic [3:0] KEY_1 = 4'd1;
  localparam logic [3:0] KEY_2 = 4'd2;
  localparam logic [3:0] KEY_3 = 4'd3;
  localparam logic [3:0] KEY_4 = 4'd4;
  localparam logic [3:0] KEY_5 = 4'd5;
  localparam logic [3:0] KEY_6 = 4'd6;
  localparam logic [3:0] KEY_7 = 4'd7;
  localparam logic [3:0] KEY_8 = 4'd8;
  localparam logic [3:0] KEY_9 = 4'd9;
  localparam logic [3:0] KEY_A = 4'd10;
  localparam logic [3:0] KEY_B = 4'd11;
  localparam logic [3:0] KEY_C = 4'd12;
  localparam logic [3:0] KEY_D = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_STAR = 4'd15;
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{KEY_1, KEY_2, KEY_3, KEY_A},
    '{KEY_4, KEY_5, KEY_6, KEY_B},
    '{KEY_7, KEY_8, KEY_9, KEY_C},
    '{KEY_STAR, KEY_0, KEY_HASH, KEY_D}
  };
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[r][c];
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer, resets to all-ones (idle keypad lines).
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, s1} <= '1;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce and key strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int SCAN_HZ = 1000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] LINE,
  output logic [3:0] COLUMN,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int DEB = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int CMAX = DWELL > DEB ? DWELL : DEB;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEB - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] col, row, low_row;
  logic [3:0] ls;
  logic lr;
  keypad_sync #(.W(4)) u_sync (.clk(clk), .rst_n(rst_n), .d(LINE), .q(ls));
  assign lr = ls[row];
  assign low_row = !ls[0] ? 2'd0 : !ls[1] ? 2'd1 : !ls[2] ? 2'd2 : 2'd3;
  assign COLUMN = ~(4'b0001 << col);
  // COLUMN stays frozen from detection until release debounce completes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SCAN;
      col <= 2'd0;
      row <= 2'd0;
      cnt <= '0;
      key_code <= 4'd0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN:
          if (cnt == DW_LAST) begin
            cnt <= '0;
            if (ls != 4'hf) begin
              row <= low_row;
              state <= PRESS_DB;
            end else col <= col + 2'd1;
          end else cnt <= cnt + 1'b1;
        PRESS_DB:
          if (lr) begin
            state <= SCAN;
            col <= col + 2'd1;
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            state <= HOLD;
            cnt <= '0;
            key_code <= key_map(row, col);
            key_valid <= 1'b1;
            key_held <= 1'b1;
          end else cnt <= cnt + 1'b1;
        HOLD:
          if (lr) begin
            state <= REL_DB;
            cnt <= '0;
          end
        REL_DB:
          if (!lr) begin
            state <= HOLD;
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            state <= SCAN;
            col <= col + 2'd1;
            cnt <= '0;
            key_held <= 1'b0;
          end else cnt <= cnt + 1'b1;
        default: state <= SCAN;
      endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: physical keypad model, table-driven presses and a key_valid scoreboard.
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] LINE, COLUMN, key_code;
  logic key_valid, key_held;
  logic [3:0] keys [4];
  logic [3:0] line_phys, ovr_val, force_hi;
  logic ovr;
  logic [3:0] q[$];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] rows;
    logic [1:0] col;
    int hold;
    logic [3:0] code;
  } vec_t;
  vec_t tbl[10];

  keypad_scanner #(.CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_MS(5)) dut (
    .clk(clk), .rst_n(rst_n), .LINE(LINE), .COLUMN(COLUMN),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // a row line is pulled low when a pressed key sits on the driven column
  always_comb begin
    line_phys = 4'hf;
    for (int r = 0; r < 4; r++) line_phys[r] = !(|(keys[r] & ~COLUMN));
  end
  assign LINE = ovr ? ovr_val : (line_phys | force_hi);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk("column_one_low", $countones(~COLUMN), 1);
      if (key_valid) begin
        if (q.size() == 0) chk("unexpected_key_valid", {28'd0, key_code}, 32'hffff);
        else chk("key_code_on_valid", key_code, q.pop_front());
      end
    end

  task automatic wait_col(input logic [3:0] tgt);
    int n = 0;
    logic [3:0] prev = COLUMN;
    @(negedge clk);
    while (!(COLUMN == tgt && prev != tgt) && n < 200) begin
      prev = COLUMN;
      @(negedge clk);
      n++;
    end
    chk("wait_col_timeout", n < 200, 1);
  endtask

  task automatic wait_pop(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, q.size(), 0);
    q.delete();
  endtask

  task automatic wait_rel(input string nm, input int lim);
    int n = 0;
    while (key_held && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, key_held, 0);
  endtask

  initial begin
    logic all_held;
    for (int r = 0; r < 4; r++) keys[r] = 4'd0;
    ovr = 1'b0;
    ovr_val = 4'hf;
    force_hi = 4'h0;
    tbl[0] = '{4'b1100, 2'd1, 20, 4'd8};
    tbl[1] = '{4'b0001, 2'd0, 20, 4'd1};
    tbl[2] = '{4'b1000, 2'd3, 20, 4'd13};
    tbl[3] = '{4'b0100, 2'd3, 20, 4'd12};
    tbl[4] = '{4'b1000, 2'd0, 20, 4'd15};
    tbl[5] = '{4'b1000, 2'd2, 20, 4'd14};
    tbl[6] = '{4'b0001, 2'd3, 20, 4'd10};
    tbl[7] = '{4'b0010, 2'd3, 20, 4'd11};
    tbl[8] = '{4'b1000, 2'd1, 20, 4'd0};
    tbl[9] = '{4'b0100, 2'd2, 20, 4'd9};

    repeat (2) @(negedge clk);
    chk("reset_column", COLUMN, 4'b1110);
    chk("reset_code", key_code, 0);
    chk("reset_valid", key_valid, 0);
    chk("reset_held", key_held, 0);
    rst_n = 1'b1;

    for (int k = 1; k <= 100; k++) begin
      logic [3:0] e;
      @(negedge clk);
      e = 4'b1111 ^ (4'b0001 << ((k / 10) % 4));
      if (k % 10 == 5) chk("idle_rotation", COLUMN, e);
    end

    // short row0 pulse caught by the column-0 sample, then dropped
    wait_col(4'b1110);
    repeat (7) @(negedge clk);
    ovr = 1'b1;
    ovr_val = 4'b1110;
    repeat (3) @(negedge clk);
    ovr_val = 4'hf;
    repeat (11) @(negedge clk);
    chk("glitch_resume_col1", COLUMN, 4'b1101);
    ovr = 1'b0;

    wait_col(4'b1011);
    keys[1][2] = 1'b1;
    q.push_back(4'd6);
    wait_pop("press6_valid");
    chk("press6_code", key_code, 6);
    chk("press6_held", key_held, 1);
    repeat (35) @(negedge clk);
    keys[1][2] = 1'b0;
    repeat (6) @(negedge clk);
    chk("press6_held_after_release", key_held, 1);
    wait_rel("press6_release_time", 6);

    foreach (tbl[i]) begin
      for (int r = 0; r < 4; r++) keys[r][tbl[i].col] = tbl[i].rows[r];
      q.push_back(tbl[i].code);
      wait_pop($sformatf("tbl%0d_valid", i));
      chk($sformatf("tbl%0d_held", i), key_held, 1);
      repeat (tbl[i].hold) @(negedge clk);
      for (int r = 0; r < 4; r++) keys[r] = 4'd0;
      wait_rel($sformatf("tbl%0d_release", i), 100);
      chk($sformatf("tbl%0d_code_kept", i), key_code, tbl[i].code);
    end

    keys[0][0] = 1'b1;
    q.push_back(4'd1);
    wait_pop("hold_glitch_valid");
    repeat (10) @(negedge clk);
    force_hi[0] = 1'b1;
    repeat (2) @(negedge clk);
    force_hi[0] = 1'b0;
    all_held = 1'b1;
    repeat (20) begin
      @(negedge clk);
      all_held &= key_held;
    end
    chk("hold_glitch_kept", all_held, 1);
    keys[0][0] = 1'b0;
    wait_rel("hold_glitch_release", 100);
    keys[0][0] = 1'b1;
    q.push_back(4'd1);
    wait_pop("repress_valid");
    chk("repress_code", key_code, 1);
    keys[0][0] = 1'b0;
    wait_rel("repress_release", 100);

    // reset lands mid press-debounce of the D key
    wait_col(4'b0111);
    keys[3][3] = 1'b1;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_column", COLUMN, 4'b1110);
    chk("async_reset_code", key_code, 0);
    chk("async_reset_held", key_held, 0);
    chk("async_reset_valid", key_valid, 0);
    keys[3][3] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("post_reset_code", key_code, 0);
    chk("post_reset_held", key_held, 0);
    chk("scoreboard_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, column-step rate in Hz; DWELL = CLK_HZ/SCAN_HZ cycles per column, DWELL >= 4.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 10, debounce window; DEB = (CLK_HZ/1000)*DEBOUNCE_MS cycles, DEB >= 1.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port LINE  input  4  keypad row lines, active low, asynchronous to clk.
REQ-007 SHALL have port COLUMN  output  4  column drive, exactly one bit low at all times.
REQ-008 SHALL have port key_code  output  4  code of last accepted key, held until next acceptance.
REQ-009 SHALL have port key_valid  output  1  single-cycle strobe on key acceptance.
REQ-010 SHALL have port key_held  output  1  high from acceptance until release debounce completes.

Function
REQ-011 SHALL pass LINE through a 2-flop synchronizer; all decisions use the synchronized value LS.
REQ-012 States SHALL be SCAN, PRESS_DB, HOLD, REL_DB.
REQ-013 SCAN: COLUMN rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing after DWELL cycles on each column.
REQ-014 SCAN: LS sampled on the last dwell cycle of each column; if any LS bit low, latch row r (lowest low index wins) and column c, freeze COLUMN, go PRESS_DB with debounce counter cleared.
REQ-015 PRESS_DB: counter increments each cycle LS[r] low; if LS[r] high on any cycle -> SCAN, resuming at column c+1 (mod 4) with dwell counter cleared, no output change.
REQ-016 PRESS_DB: when LS[r] has been low DEB consecutive cycles -> go HOLD; in the cycle of that transition key_code loads map(r,c) and key_valid pulses high for exactly one cycle.
REQ-017 Mapping (row,col): r0 = 1,2,3,10; r1 = 4,5,6,11; r2 = 7,8,9,12; r3 = 15,0,14,13.
REQ-018 HOLD: key_held high, COLUMN frozen, no further key_valid regardless of other rows; LS[r] high -> REL_DB with counter cleared.
REQ-019 REL_DB: counter increments each cycle LS[r] high; LS[r] low -> back to HOLD; DEB consecutive high cycles -> SCAN at column c+1, key_held low on entry to SCAN.
REQ-020 Key auto-repeat SHALL NOT occur; a new key_valid requires full release debounce and a fresh detection.
REQ-021 Counters SHALL be sized ceil(log2(max(DWELL,DEB)+1)) and never wrap within a state.

Reset
REQ-022 On rst_n low, asynchronously: state SCAN, COLUMN 1110, key_code 0, key_valid 0, key_held 0, counters 0, synchronizer flops 1111.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL discard the pending key with no key_valid after release of reset.
REQ-024 After rst_n deasserts, first LS sample SHALL occur no earlier than the last cycle of the first full dwell.

Structure
REQ-025 Package keypad_pkg SHALL hold the state encoding, the 16 key-code constants (0-9, A=10, B=11, C=12, D=13, hash=14, star=15) and the map table.
REQ-026 Sub-module keypad_sync (parameterised width, 2-flop, async active-low reset to all-ones) SHALL implement REQ-011.

Verification (CLK_HZ=1000, SCAN_HZ=100 -> DWELL=10; DEBOUNCE_MS=5 -> DEB=5)
REQ-027 Reset, LINE=1111 for 100 cycles -> COLUMN cycles 1110,1101,1011,0111 every 10 cycles, key_valid never high.
REQ-028 Press row1 when COLUMN=1011, held 50 cycles -> one key_valid pulse, key_code=6, key_held high until 5 cycles (+2 sync) after release.
REQ-029 Row0 low for 3 cycles only on column 0 -> no key_valid, scanning resumes at COLUMN=1101.
REQ-030 Rows 2 and 3 both low on column 1 -> key_code=8 (row 2 wins), single pulse.
REQ-031 Held key with 2-cycle high glitch during HOLD -> remains HOLD, no second key_valid; clean release then re-press -> second pulse.
REQ-032 rst_n pulsed low during PRESS_DB for row3/col3 -> outputs reset immediately, no key_valid for code 13 afterwards unless re-detected.
